// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises rx, samples each bit mid-period and hands bytes
// to the consumer through a one-entry valid/ready buffer with framing/overrun pulses.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [CNT_W-1:0]       clk_cnt, clk_cnt_nxt;
  logic [BIT_W-1:0]       bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   shift_en, deliver, ferr_set;

  // Synchroniser flops reset to 1 so an idle line is never mistaken for a start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt + CNT_W'(1);
    bit_cnt_nxt = bit_cnt;
    shift_en    = 1'b0;
    deliver     = 1'b0;
    ferr_set    = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_nxt = '0;
        bit_cnt_nxt = '0;
        if (!rxs) state_nxt = START;
      end
      START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_nxt = '0;
          state_nxt   = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == FULL_LAST) begin
          clk_cnt_nxt = '0;
          shift_en    = 1'b1;
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_LAST) state_nxt = STOP;
        end
      end
      STOP: begin
        if (clk_cnt == FULL_LAST) begin
          clk_cnt_nxt = '0;
          if (rxs) begin
            deliver   = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        clk_cnt_nxt = '0;
        if (rxs) state_nxt = IDLE;
      end
      default: begin
        clk_cnt_nxt = '0;
        state_nxt   = IDLE;
      end
    endcase
  end

  // LSB arrives first, so shift in from the top
  always_ff @(posedge clk) begin
    if (shift_en) shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overrun   <= 1'b0;
      if (deliver) begin
        if (!data_valid || data_ready) begin
          data_out   <= shift_q;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: frames driven bit-by-bit, outputs sampled mid-cycle.
module tb_uart_rx_byte;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int         vcnt, fcnt, ocnt, bfirst, blast, vfirst;
  logic [7:0] vdata;

  uart_rx_byte #(.CLKS_PER_BIT(10), .DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Iteration n drives rx just after edge n; rx(n) is seen by the FSM at edge n+3 (T0 = edge 3),
  // so a sample taken after edge n corresponds to cycle T0 + (n-2).
  task automatic run_frame(input logic [7:0] d, input logic stop_bit, input int low_after,
                           input int ncyc, input int abort_at,
                           output int vc, output int fc, output int oc,
                           output int bf, output int bl, output int vf, output logic [7:0] vd);
    int bitn;
    vc = 0; fc = 0; oc = 0; bf = -1; bl = -1; vf = -1; vd = 8'h00;
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk); #1;
      if (n == abort_at) return;
      bitn = n / 10;
      if (bitn == 0)      rx = 1'b0;
      else if (bitn <= 8) rx = d[bitn-1];
      else if (bitn == 9) rx = stop_bit;
      else                rx = (n < 100 + low_after) ? 1'b0 : 1'b1;
      #3;
      if (data_valid) begin
        vc++;
        vd = data_out;
        if (vf < 0) vf = n;
      end
      if (frame_err) fc++;
      if (overrun) oc++;
      if (busy) begin
        if (bf < 0) bf = n;
        bl = n;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #4;
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    // 0x00 with good stop bit
    run_frame(8'h00, 1'b1, 0, 110, -1, vcnt, fcnt, ocnt, bfirst, blast, vfirst, vdata);
    check("f00_valid_cycles", 32'(vcnt), 32'd1);
    check("f00_data", 32'(vdata), 32'h00);
    check("f00_frame_err", 32'(fcnt), 32'd0);
    check("f00_overrun", 32'(ocnt), 32'd0);

    // 0xA5 timing: busy T0+1..T0+95, valid at T0+96
    run_frame(8'hA5, 1'b1, 0, 110, -1, vcnt, fcnt, ocnt, bfirst, blast, vfirst, vdata);
    check("fA5_data", 32'(vdata), 32'hA5);
    check("fA5_valid_first", 32'(vfirst), 32'd98);
    check("fA5_busy_first", 32'(bfirst), 32'd3);
    check("fA5_busy_last", 32'(blast), 32'd97);
    check("fA5_valid_cycles", 32'(vcnt), 32'd1);

    // 3-cycle glitch: no data, no flag, busy drops at T0+6
    vcnt = 0; fcnt = 0; bfirst = -1; blast = -1;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      rx = (n < 3) ? 1'b0 : 1'b1;
      #3;
      if (data_valid) vcnt++;
      if (frame_err || overrun) fcnt++;
      if (busy) begin
        if (bfirst < 0) bfirst = n;
        blast = n;
      end
    end
    check("glitch_valid", 32'(vcnt), 32'd0);
    check("glitch_flags", 32'(fcnt), 32'd0);
    check("glitch_busy_first", 32'(bfirst), 32'd3);
    check("glitch_busy_last", 32'(blast), 32'd7);
    check("glitch_idle", 32'(busy), 32'h0);

    // 0x3C with stop=0, held low 30 more cycles
    run_frame(8'h3C, 1'b0, 30, 150, -1, vcnt, fcnt, ocnt, bfirst, blast, vfirst, vdata);
    check("ferr_pulses", 32'(fcnt), 32'd1);
    check("ferr_valid", 32'(vcnt), 32'd0);
    check("ferr_overrun", 32'(ocnt), 32'd0);
    check("ferr_idle_after", 32'(busy), 32'h0);
    run_frame(8'h55, 1'b1, 0, 110, -1, vcnt, fcnt, ocnt, bfirst, blast, vfirst, vdata);
    check("after_break_data", 32'(vdata), 32'h55);
    check("after_break_valid", 32'(vcnt), 32'd1);
    check("after_break_ferr", 32'(fcnt), 32'd0);

    // Overrun: consumer stalled across two frames
    data_ready = 1'b0;
    run_frame(8'h11, 1'b1, 0, 110, -1, vcnt, fcnt, ocnt, bfirst, blast, vfirst, vdata);
    check("ovr_first_data", 32'(vdata), 32'h11);
    check("ovr_first_overrun", 32'(ocnt), 32'd0);
    run_frame(8'h22, 1'b1, 0, 110, -1, vcnt, fcnt, ocnt, bfirst, blast, vfirst, vdata);
    check("ovr_pulses", 32'(ocnt), 32'd1);
    check("ovr_kept_data", 32'(data_out), 32'h11);
    check("ovr_valid_held", 32'(data_valid), 32'h1);
    check("ovr_no_ferr", 32'(fcnt), 32'd0);
    @(posedge clk); #1 data_ready = 1'b1;
    #3 check("ready_same_cycle", 32'(data_valid), 32'h1);
    @(posedge clk); #4;
    check("ready_valid_drop", 32'(data_valid), 32'h0);

    // Reset mid-frame with a byte sitting in the buffer
    data_ready = 1'b0;
    run_frame(8'h5A, 1'b1, 0, 110, -1, vcnt, fcnt, ocnt, bfirst, blast, vfirst, vdata);
    check("pre_rst_data", 32'(data_out), 32'h5A);
    run_frame(8'h77, 1'b1, 0, 110, 55, vcnt, fcnt, ocnt, bfirst, blast, vfirst, vdata);
    check("pre_rst_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(data_valid), 32'h0);
    check("async_rst_data", 32'(data_out), 32'h00);
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_flags", 32'({frame_err, overrun}), 32'h0);
    rx = 1'b1;
    data_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    run_frame(8'h81, 1'b1, 0, 110, -1, vcnt, fcnt, ocnt, bfirst, blast, vfirst, vdata);
    check("post_rst_data", 32'(vdata), 32'h81);
    check("post_rst_valid", 32'(vcnt), 32'd1);
    check("post_rst_flags", 32'(fcnt + ocnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
